decode_issue: RTL

DECODE_ISSUE -- requirements
Module: decode_issue

---
 rtl/decode_issue_pkg.sv | 71 +++++++
 rtl/decode_issue_regfile.sv | 55 +++++
 rtl/decode_issue.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/decode_issue_pkg.sv
// Shared definitions for the decode/issue stage: widths, class codes,
// one-hot class bit positions and the run/halt state encoding.
package decode_issue_pkg;

  localparam int DEF_WORD   = 32;
  localparam int DEF_ADDR   = 32;
  localparam int DEF_W_RD   = 5;
  localparam int DEF_W_OPC  = 4;
  localparam int DEF_W_DOPC = 12;

  // Instruction class codes carried in inst[31:28]
  localparam logic [3:0] CLS_ADDSUB = 4'd0;
  localparam logic [3:0] CLS_MUL    = 4'd1;
  localparam logic [3:0] CLS_DIV    = 4'd2;
  localparam logic [3:0] CLS_ABS    = 4'd3;
  localparam logic [3:0] CLS_SHIFT  = 4'd4;
  localparam logic [3:0] CLS_LOGIC  = 4'd5;
  localparam logic [3:0] CLS_SET    = 4'd6;
  localparam logic [3:0] CLS_LOAD   = 4'd7;
  localparam logic [3:0] CLS_STORE  = 4'd8;
  localparam logic [3:0] CLS_BRANCH = 4'd9;
  localparam logic [3:0] CLS_NOP    = 4'd10;
  localparam logic [3:0] CLS_HALT   = 4'd11;

  // Bit positions inside the one-hot class vector (MSB = addsub)
  localparam int DOPC_ADDSUB = 11;
  localparam int DOPC_MUL    = 10;
  localparam int DOPC_DIV    = 9;
  localparam int DOPC_ABS    = 8;
  localparam int DOPC_SHIFT  = 7;
  localparam int DOPC_LOGIC  = 6;
  localparam int DOPC_SET    = 5;
  localparam int DOPC_LOAD   = 4;
  localparam int DOPC_STORE  = 3;
  localparam int DOPC_BRANCH = 2;
  localparam int DOPC_NOP    = 1;
  localparam int DOPC_HALT   = 0;

  typedef enum logic {
    S_RUN,
    S_HALTED
  } state_t;

  // Class code to one-hot; unassigned codes 12..15 behave as nop
  function automatic logic [DEF_W_DOPC-1:0] class_to_dopc(input logic [3:0] cls);
    logic [DEF_W_DOPC-1:0] d;
    d = '0;
    case (cls)
      CLS_ADDSUB: d[DOPC_ADDSUB] = 1'b1;
      CLS_MUL:    d[DOPC_MUL]    = 1'b1;
      CLS_DIV:    d[DOPC_DIV]    = 1'b1;
      CLS_ABS:    d[DOPC_ABS]    = 1'b1;
      CLS_SHIFT:  d[DOPC_SHIFT]  = 1'b1;
      CLS_LOGIC:  d[DOPC_LOGIC]  = 1'b1;
      CLS_SET:    d[DOPC_SET]    = 1'b1;
      CLS_LOAD:   d[DOPC_LOAD]   = 1'b1;
      CLS_STORE:  d[DOPC_STORE]  = 1'b1;
      CLS_BRANCH: d[DOPC_BRANCH] = 1'b1;
      CLS_NOP:    d[DOPC_NOP]    = 1'b1;
      CLS_HALT:   d[DOPC_HALT]   = 1'b1;
      default:    d[DOPC_NOP]    = 1'b1;
    endcase
    return d;
  endfunction

  // Classes addsub through load produce a register result
  function automatic logic class_writes(input logic [3:0] cls);
    return (cls <= CLS_LOAD);
  endfunction

endpackage

// File: rtl/decode_issue_regfile.sv
// Register file: R0 hardwired to zero, two combinational read ports,
// one synchronous write port with same-cycle write-to-read bypass.
module decode_issue_regfile
  import decode_issue_pkg::*;
#(
  parameter int WORD = DEF_WORD,
  parameter int W_RD = DEF_W_RD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [W_RD-1:0] waddr,
  input  logic [WORD-1:0] wdata,
  input  logic [W_RD-1:0] raddr_a,
  output logic [WORD-1:0] rdata_a,
  input  logic [W_RD-1:0] raddr_b,
  output logic [WORD-1:0] rdata_b
);

  localparam int NREGS = 2 ** W_RD;

  logic [WORD-1:0] regs [NREGS];

  // Storage update; reset clears every entry and beats a concurrent write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  // Read port A with bypass from the write port; R0 always reads zero
  always_comb begin
    rdata_a = regs[raddr_a];
    if (raddr_a == '0) begin
      rdata_a = '0;
    end else if (we && waddr == raddr_a) begin
      rdata_a = wdata;
    end
  end

  // Read port B with the same bypass rules as port A
  always_comb begin
    rdata_b = regs[raddr_b];
    if (raddr_b == '0) begin
      rdata_b = '0;
    end else if (we && waddr == raddr_b) begin
      rdata_b = wdata;
    end
  end

endmodule

// File: rtl/decode_issue.sv
// Decode and issue stage: decodes the fetched word, checks the register
// scoreboard, reads operands and presents them in a single issue slot.
module decode_issue
  import decode_issue_pkg::*;
#(
  parameter int WORD   = DEF_WORD,
  parameter int ADDR   = DEF_ADDR,
  parameter int W_RD   = DEF_W_RD,
  parameter int W_OPC  = DEF_W_OPC,
  parameter int W_DOPC = DEF_W_DOPC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              v_i,
  input  logic [31:0]       inst_i,
  input  logic [ADDR-1:0]   addr_i,
  output logic              stall_o,
  output logic              v_o,
  input  logic              stall_i,
  output logic [WORD-1:0]   src_o,
  output logic [WORD-1:0]   dest_o,
  output logic              wb_o,
  output logic [W_RD-1:0]   rd_num_o,
  output logic [W_DOPC-1:0] dopc_o,
  output logic [W_OPC-1:0]  opc_o,
  output logic [ADDR-1:0]   origaddr_o,
  input  logic              wb_i,
  input  logic [W_RD-1:0]   rd_num_i,
  input  logic [WORD-1:0]   rd_data_i,
  output logic              halted_o
);

  localparam int NREGS = 2 ** W_RD;

  // Instruction fields
  logic [3:0]        cls;
  logic [W_OPC-1:0]  opc;
  logic [W_RD-1:0]   rd;
  logic [W_RD-1:0]   rs;
  logic              imm_flag;
  logic [12:0]       imm13;
  logic [WORD-1:0]   imm_ext;
  logic [W_DOPC-1:0] dec_dopc;
  logic              dec_wb;

  assign cls      = inst_i[31:28];
  assign opc      = inst_i[27:24];
  assign rd       = inst_i[23:19];
  assign rs       = inst_i[18:14];
  assign imm_flag = inst_i[13];
  assign imm13    = inst_i[12:0];
  assign imm_ext  = {{(WORD-13){imm13[12]}}, imm13};
  assign dec_dopc = class_to_dopc(cls);
  assign dec_wb   = class_writes(cls);

  logic [WORD-1:0] rd_val;
  logic [WORD-1:0] rs_val;
  logic [WORD-1:0] src_val;

  decode_issue_regfile #(
    .WORD (WORD),
    .W_RD (W_RD)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (wb_i),
    .waddr   (rd_num_i),
    .wdata   (rd_data_i),
    .raddr_a (rd),
    .rdata_a (rd_val),
    .raddr_b (rs),
    .rdata_b (rs_val)
  );

  assign src_val = imm_flag ? imm_ext : rs_val;

  state_t           state;
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] clr_mask;
  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] busy_eff;
  logic             hazard;
  logic             accept;

  // Writeback this cycle releases its register for hazard purposes
  always_comb begin
    clr_mask = '0;
    if (wb_i) begin
      clr_mask[rd_num_i] = 1'b1;
    end
  end

  assign busy_eff = busy & ~clr_mask;
  assign hazard   = v_i && (busy_eff[rd] || (!imm_flag && busy_eff[rs]));
  assign stall_o  = (state == S_HALTED) || hazard || (v_o && stall_i);
  assign accept   = v_i && !stall_o;

  // Accepted register writers reserve their destination (never R0)
  always_comb begin
    set_mask = '0;
    if (accept && dec_wb && rd != '0) begin
      set_mask[rd] = 1'b1;
    end
  end

  // Scoreboard update; a reservation wins over a same-cycle release
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= ((busy & ~clr_mask) | set_mask) & ~NREGS'(1);
    end
  end

  // Issue slot: load on accept, hold under back-pressure, otherwise drain
  always_ff @(posedge clk) begin
    if (rst) begin
      v_o        <= 1'b0;
      src_o      <= '0;
      dest_o     <= '0;
      wb_o       <= 1'b0;
      rd_num_o   <= '0;
      dopc_o     <= '0;
      opc_o      <= '0;
      origaddr_o <= '0;
    end else if (accept) begin
      v_o        <= 1'b1;
      src_o      <= src_val;
      dest_o     <= rd_val;
      wb_o       <= dec_wb;
      rd_num_o   <= rd;
      dopc_o     <= dec_dopc;
      opc_o      <= opc;
      origaddr_o <= addr_i;
    end else if (!(v_o && stall_i)) begin
      v_o    <= 1'b0;
      wb_o   <= 1'b0;
      dopc_o <= '0;
    end
  end

  // Run/halt FSM; once a halt is accepted only reset brings it back
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_RUN;
      halted_o <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (accept && dec_dopc[DOPC_HALT]) begin
            state    <= S_HALTED;
            halted_o <= 1'b1;
          end
        end
        S_HALTED: begin
          state    <= S_HALTED;
          halted_o <= 1'b1;
        end
        default: begin
          state    <= S_RUN;
          halted_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
